// File: rtl/alu_pkg.sv
// alu_pkg: shared width default, command opcodes and FSM state encodings for the ALU front end.
package alu_pkg;
    localparam int ALU_WIDTH = 8;
    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_LDB = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_OUT = 3'b101;
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;
endpackage

// File: rtl/addsub_core.sv
// addsub_core: combinational adder/subtractor; subtraction is two's-complement add of inverted b plus one.
module addsub_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b ^ {WIDTH{sub}}} + {{WIDTH{1'b0}}, sub};
endmodule

// File: rtl/alu_accumulator_unit.sv
// alu_accumulator_unit: A/B registers, command/response handshake FSM and result write-back.
// Optional carry/zero flag registers are built when ALU_FLAGS_EN is defined.
module alu_accumulator_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [WIDTH-1:0] acc_q,
    output logic             flag_c,
    output logic             flag_z
);
    state_t           state;
    logic [WIDTH-1:0] a_q, b_q, sum;
    logic             sub_q, cout;

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a(a_q), .b(b_q), .sub(sub_q), .s(sum), .cout(cout)
    );

    assign cmd_ready = (state == ST_IDLE);
    assign acc_q     = a_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            res_data  <= '0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    case (cmd_op)
                        OP_LDA: a_q <= cmd_data;
                        OP_LDB: b_q <= cmd_data;
                        OP_ADD, OP_SUB: begin
                            sub_q <= cmd_op[2];
                            state <= ST_EXEC;
                        end
                        OP_OUT: begin
                            res_data  <= a_q;
                            res_valid <= 1'b1;
                            state     <= ST_RESP;
                        end
                        default: ;
                    endcase
                end
                ST_EXEC: begin
                    a_q       <= sum;
                    res_data  <= sum;
                    res_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: if (res_ready) begin
                    res_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_FLAGS_EN
    logic c_q, z_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= 1'b0;
            z_q <= 1'b0;
        end else if (state == ST_EXEC) begin
            c_q <= cout;
            z_q <= (sum == '0);
        end
    end
    assign flag_c = c_q;
    assign flag_z = z_q;
`else
    logic unused_cout;
    assign unused_cout = cout;
    assign flag_c = 1'b0;
    assign flag_z = 1'b0;
`endif
endmodule
